// File: rtl/op_seq_pkg.sv
// Shared definitions for the operand sequencer.
//   state_t      : sequencer FSM states
//   FIFO_DEPTH   : host vector FIFO depth
//   SWEEP_LEN    : vectors per sweep half (one operand walks 0..15)
//   NUM_VEC      : vectors in a complete sweep run
//   zext_nibble  : widen a 4-bit operand to the 8-bit processor input
package op_seq_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int SWEEP_LEN  = 16;
    localparam int NUM_VEC    = 32;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWEEP_B,
        ST_SWEEP_A,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [7:0] zext_nibble(input logic [3:0] n);
        return {4'h0, n};
    endfunction

endpackage

// File: rtl/op_fifo.sv
// Small host vector FIFO (4 x 8 bit) with first-word-fall-through head.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset (empties FIFO)
//   push, push_data  : write request and data (ignored when full)
//   pop              : remove head entry (ignored when empty)
//   pop_data         : current head entry, valid while !empty
//   full, empty      : occupancy flags
//   count            : occupancy 0..4
module op_fifo
    import op_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [7:0]       mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // The head is read combinationally so a pop can load the operand
    // registers at the same edge.
    assign pop_data = mem_reg[rd_ptr_reg];

    // Entries are cleared on reset so aborted contents never reappear.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Pointers are 2 bits wide so they wrap modulo the depth naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/op_sequencer.sv
// Operand sequencer: feeds (a,b) vectors to a processor either as an
// exhaustive 32-vector sweep or by draining host-written FIFO entries.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   ena               : global enable, low freezes everything
//   start, mode       : begin run in IDLE; mode 0 sweep, 1 drain FIFO
//   wr_valid, wr_data : host writes {a[3:0], b[3:0]}; wr_ready = !full
//   op_a, op_b        : registered zero-extended operands
//   op_valid, idx     : new-vector strobe and index within run
//   busy, done        : run in progress / one-cycle completion pulse
module op_sequencer
    import op_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       mode,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       op_valid,
    output logic [5:0] idx,
    output logic       busy,
    output logic       done
);

    state_t     state_reg, state_next;
    logic [7:0] op_a_reg, op_a_next;
    logic [7:0] op_b_reg, op_b_next;
    logic [5:0] idx_reg, idx_next;
    logic       op_valid_reg, op_valid_next;

    logic             fifo_push;
    logic             fifo_pop;
    logic             pop_req;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_count;

    assign unused_count = ^fifo_count;

    // Ready reflects the registered full flag only; a pop in the same
    // cycle does not make room early.
    assign wr_ready  = ~fifo_full;
    assign fifo_push = ena & wr_valid & ~fifo_full;
    assign fifo_pop  = ena & pop_req;

    op_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            idx_reg      <= '0;
            op_valid_reg <= 1'b0;
        end else if (ena) begin
            state_reg    <= state_next;
            op_a_reg     <= op_a_next;
            op_b_reg     <= op_b_next;
            idx_reg      <= idx_next;
            op_valid_reg <= op_valid_next;
        end
    end

    // Operand/index registers hold by default; only cycles that emit a
    // vector overwrite them and raise op_valid.
    always_comb begin
        state_next    = state_reg;
        op_a_next     = op_a_reg;
        op_b_next     = op_b_reg;
        idx_next      = idx_reg;
        op_valid_next = 1'b0;
        pop_req       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (!mode) begin
                        state_next    = ST_SWEEP_B;
                        op_a_next     = '0;
                        op_b_next     = '0;
                        idx_next      = '0;
                        op_valid_next = 1'b1;
                    end else if (!fifo_empty) begin
                        state_next    = ST_DRAIN;
                        pop_req       = 1'b1;
                        op_a_next     = zext_nibble(fifo_head[7:4]);
                        op_b_next     = zext_nibble(fifo_head[3:0]);
                        idx_next      = '0;
                        op_valid_next = 1'b1;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_SWEEP_B: begin
                op_valid_next = 1'b1;
                op_a_next     = '0;
                idx_next      = idx_reg + 6'd1;
                if (op_b_reg[3:0] == 4'(SWEEP_LEN - 1)) begin
                    // B half complete: A half restarts at (0,0).
                    state_next = ST_SWEEP_A;
                    op_b_next  = '0;
                end else begin
                    op_b_next = op_b_reg + 8'd1;
                end
            end
            ST_SWEEP_A: begin
                if (op_a_reg[3:0] == 4'(SWEEP_LEN - 1)) begin
                    state_next = ST_DONE;
                end else begin
                    op_valid_next = 1'b1;
                    op_a_next     = op_a_reg + 8'd1;
                    op_b_next     = '0;
                    idx_next      = idx_reg + 6'd1;
                end
            end
            ST_DRAIN: begin
                if (!fifo_empty) begin
                    pop_req       = 1'b1;
                    op_a_next     = zext_nibble(fifo_head[7:4]);
                    op_b_next     = zext_nibble(fifo_head[3:0]);
                    idx_next      = idx_reg + 6'd1;
                    op_valid_next = 1'b1;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign op_a     = op_a_reg;
    assign op_b     = op_b_reg;
    assign idx      = idx_reg;
    assign op_valid = op_valid_reg;
    assign busy     = (state_reg == ST_SWEEP_B) || (state_reg == ST_SWEEP_A) ||
                      (state_reg == ST_DRAIN);
    assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: directed table, hand-written
// corner sequences and randomized traffic against a run-level model.
module tb_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_valid;
    logic [5:0] idx;
    logic       busy;
    logic       done;

    op_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .mode     (mode),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_valid (op_valid),
        .idx      (idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 idle, 1 sweep, 2 drain, 3 done.
    logic [7:0] q[$];
    int         m_phase;
    int         m_k;
    logic       m_valid;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [5:0] m_idx;

    int         valid_seen;
    logic [7:0] popped[$];

    typedef struct {
        logic        ena;
        logic        start;
        logic        mode;
        logic        wr_valid;
        logic [7:0]  wr_data;
        logic [25:0] exp;
    } vec_t;

    function automatic logic [25:0] pk(input logic v, input logic [7:0] a,
                                       input logic [7:0] b, input logic [5:0] i,
                                       input logic bz, input logic dn, input logic rd);
        return {v, a, b, i, bz, dn, rd};
    endfunction

    function automatic logic [25:0] obs();
        return {op_valid, op_a, op_b, idx, busy, done, wr_ready};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_phase = 0;
        m_k     = 0;
        m_valid = 1'b0;
        m_a     = '0;
        m_b     = '0;
        m_idx   = '0;
    endtask

    task automatic emit_sweep();
        m_valid = 1'b1;
        m_idx   = 6'(m_k);
        m_a     = (m_k < 16) ? 8'd0 : 8'(m_k - 16);
        m_b     = (m_k < 16) ? 8'(m_k) : 8'd0;
    endtask

    task automatic emit_pop(input logic [5:0] i);
        logic [7:0] e;
        e       = q.pop_front();
        m_valid = 1'b1;
        m_a     = {4'h0, e[7:4]};
        m_b     = {4'h0, e[3:0]};
        m_idx   = i;
    endtask

    // One enabled clock edge of the model; pop decisions use the
    // occupancy seen before the edge, and the push lands afterwards.
    task automatic model_edge();
        int pre;
        bit do_push;
        pre     = q.size();
        do_push = wr_valid && (pre < 4);
        m_valid = 1'b0;
        case (m_phase)
            0: if (start) begin
                if (!mode) begin
                    m_phase = 1;
                    m_k     = 0;
                    emit_sweep();
                end else if (pre > 0) begin
                    m_phase = 2;
                    emit_pop(6'd0);
                end else begin
                    m_phase = 3;
                end
            end
            1: begin
                m_k++;
                if (m_k == 32) m_phase = 3;
                else           emit_sweep();
            end
            2: begin
                if (pre > 0) emit_pop(m_idx + 6'd1);
                else         m_phase = 3;
            end
            default: m_phase = 0;
        endcase
        if (do_push) q.push_back(wr_data);
    endtask

    function automatic logic [25:0] model_exp();
        return pk(m_valid, m_a, m_b, m_idx, (m_phase == 1) || (m_phase == 2),
                  m_phase == 3, q.size() < 4);
    endfunction

    task automatic step(input logic e, input logic s, input logic md,
                        input logic wv, input logic [7:0] wd, input string name);
        ena      = e;
        start    = s;
        mode     = md;
        wr_valid = wv;
        wr_data  = wd;
        @(posedge clk);
        if (e) model_edge();
        #1;
        chk(name, 32'(obs()), 32'(model_exp()));
        if (e && op_valid) begin
            valid_seen++;
            popped.push_back({op_a[3:0], op_b[3:0]});
        end
    endtask

    task automatic idle_step(input string name);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("reset_state", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 1)));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t       tbl[10];
    logic [7:0] fill[5];

    initial begin
        model_reset();
        #12;
        chk("por_state", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 1)));
        @(negedge clk);
        rst_n = 1'b1;

        // Drain of three vectors, then start with an empty FIFO.
        tbl[0] = '{1, 0, 0, 1, 8'h3A, pk(0, 0, 0, 0, 0, 0, 1)};
        tbl[1] = '{1, 0, 0, 1, 8'h5C, pk(0, 0, 0, 0, 0, 0, 1)};
        tbl[2] = '{1, 0, 0, 1, 8'hF1, pk(0, 0, 0, 0, 0, 0, 1)};
        tbl[3] = '{1, 1, 1, 0, 8'h00, pk(1, 3, 10, 0, 1, 0, 1)};
        tbl[4] = '{1, 0, 0, 0, 8'h00, pk(1, 5, 12, 1, 1, 0, 1)};
        tbl[5] = '{1, 0, 0, 0, 8'h00, pk(1, 15, 1, 2, 1, 0, 1)};
        tbl[6] = '{1, 0, 0, 0, 8'h00, pk(0, 15, 1, 2, 0, 1, 1)};
        tbl[7] = '{1, 0, 0, 0, 8'h00, pk(0, 15, 1, 2, 0, 0, 1)};
        tbl[8] = '{1, 1, 1, 0, 8'h00, pk(0, 15, 1, 2, 0, 1, 1)};
        tbl[9] = '{1, 0, 0, 0, 8'h00, pk(0, 15, 1, 2, 0, 0, 1)};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].ena, tbl[i].start, tbl[i].mode, tbl[i].wr_valid,
                 tbl[i].wr_data, "table_model");
            chk($sformatf("table_%0d", i), 32'(obs()), 32'(tbl[i].exp));
            $display("[TB] table %0d: op_valid=%0d a=%0d b=%0d idx=%0d done=%0d",
                     i, op_valid, op_a, op_b, idx, done);
        end

        // Full sweep.
        do_reset();
        valid_seen = 0;
        step(1, 1, 0, 0, 8'h00, "sweep_start");
        chk("sweep_first", 32'(obs()), 32'(pk(1, 0, 0, 0, 1, 0, 1)));
        repeat (31) idle_step("sweep");
        chk("sweep_last", 32'(obs()), 32'(pk(1, 15, 0, 31, 1, 0, 1)));
        idle_step("sweep_end");
        chk("sweep_done", 32'(obs()), 32'(pk(0, 15, 0, 31, 0, 1, 1)));
        idle_step("sweep_idle");
        chk("sweep_after", 32'(obs()), 32'(pk(0, 15, 0, 31, 0, 0, 1)));
        chk("sweep_count", 32'(valid_seen), 32'd32);
        $display("[TB] sweep: %0d vectors", valid_seen);

        // FIFO fill beyond capacity.
        do_reset();
        fill[0] = 8'h12; fill[1] = 8'h34; fill[2] = 8'h56; fill[3] = 8'h78; fill[4] = 8'h9A;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, fill[i], "fill");
            if (i == 3) chk("full_ready_low", 32'(wr_ready), 32'd0);
        end
        popped.delete();
        step(1, 1, 1, 0, 8'h00, "full_drain_start");
        repeat (5) idle_step("full_drain");
        chk("full_drain_len", 32'(popped.size()), 32'd4);
        for (int i = 0; i < 4 && i < popped.size(); i++)
            chk($sformatf("full_drain_%0d", i), 32'(popped[i]), 32'(fill[i]));
        $display("[TB] fifo full: drained %0d vectors", popped.size());

        // Enable freeze during sweep.
        do_reset();
        valid_seen = 0;
        step(1, 1, 0, 0, 8'h00, "frz_start");
        repeat (7) idle_step("frz_run");
        chk("frz_at7", 32'(obs()), 32'(pk(1, 0, 7, 7, 1, 0, 1)));
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 8'h00, "frz_hold");
            chk($sformatf("frz_hold_%0d", i), 32'(obs()), 32'(pk(1, 0, 7, 7, 1, 0, 1)));
        end
        idle_step("frz_resume");
        chk("frz_resume8", 32'(obs()), 32'(pk(1, 0, 8, 8, 1, 0, 1)));
        repeat (25) idle_step("frz_rest");
        chk("frz_count", 32'(valid_seen), 32'd32);
        $display("[TB] freeze: %0d vectors", valid_seen);

        // Reset mid-sweep.
        do_reset();
        step(1, 0, 0, 1, 8'hAB, "abort_push");
        step(1, 1, 0, 0, 8'h00, "abort_start");
        repeat (20) idle_step("abort_run");
        chk("abort_at20", 32'(obs()), 32'(pk(1, 4, 0, 20, 1, 0, 1)));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("abort_reset", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 1)));
        @(posedge clk);
        #1;
        chk("abort_hold", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 1)));
        @(negedge clk);
        rst_n = 1'b1;
        popped.delete();
        step(1, 1, 1, 0, 8'h00, "abort_fifo_empty");
        chk("abort_fifo_discard", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 1, 1)));
        idle_step("abort_idle");
        valid_seen = 0;
        step(1, 1, 0, 0, 8'h00, "abort_restart");
        repeat (33) idle_step("abort_sweep");
        chk("abort_count", 32'(valid_seen), 32'd32);
        $display("[TB] reset abort: restart gave %0d vectors", valid_seen);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), "random");
        end
        $display("[TB] random: 3000 cycles");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
